// File: rtl/mcu_spi_select.sv
// MCU SPI source select: forwards either the on-board BL616 or an external
// M0S Dock to the core's mcu_* inputs. Switches to the M0S once its presence
// is qualified and both buses are idle, then stays there until reset.
module mcu_spi_select #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DET_CYCLES  = 16,
  parameter int unsigned IDLE_GUARD  = 4
) (
  input  logic clk32,
  input  logic reset,
  input  logic int_sclk,
  input  logic int_csn,
  input  logic int_mosi,
  input  logic ext_sclk,
  input  logic ext_csn,
  input  logic ext_mosi,
  input  logic core_miso,
  input  logic core_intn,
  output logic mcu_sclk,
  output logic mcu_csn,
  output logic mcu_mosi,
  output logic int_miso,
  output logic ext_miso,
  output logic int_irqn,
  output logic ext_irqn,
  output logic ext_active
);

  localparam int unsigned DET_W = $clog2(DET_CYCLES + 1);
  localparam int unsigned GRD_W = $clog2(IDLE_GUARD + 1);
  localparam int unsigned PADS  = 6;
  // Bit order: {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk}
  localparam logic [PADS-1:0] SYNC_RST = 6'b010010;

  typedef enum logic [1:0] {
    ST_INT  = 2'd0,
    ST_PEND = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DET_W-1:0] det_cnt, det_nxt;
  logic [GRD_W-1:0] guard_cnt, guard_nxt;
  logic [PADS-1:0]  pads;
  logic [PADS-1:0]  pads_s;
  logic [PADS-1:0]  sync_q [SYNC_STAGES];

  logic int_sclk_s, int_csn_s, int_mosi_s;
  logic ext_sclk_s, ext_csn_s, ext_mosi_s;

  assign pads   = {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk};
  assign pads_s = sync_q[SYNC_STAGES-1];
  assign {ext_mosi_s, ext_csn_s, ext_sclk_s, int_mosi_s, int_csn_s, int_sclk_s} = pads_s;

  // Fan-out of core response to both MCUs, independent of selection
  assign int_miso = core_miso;
  assign ext_miso = core_miso;
  assign int_irqn = core_intn;
  assign ext_irqn = core_intn;

  // Synchroniser chains for all six pad inputs
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= pads;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // State and qualification counters
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state     <= ST_INT;
      det_cnt   <= '0;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      det_cnt   <= det_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  // Next state: presence detect in INT, idle guard in PEND, EXT is terminal
  always_comb begin
    state_nxt = state;
    det_nxt   = '0;
    guard_nxt = '0;
    unique case (state)
      ST_INT: begin
        if (!ext_csn_s) begin
          det_nxt = (det_cnt == DET_W'(DET_CYCLES)) ? det_cnt : det_cnt + DET_W'(1);
        end
        if (det_nxt == DET_W'(DET_CYCLES)) begin
          state_nxt = ST_PEND;
          det_nxt   = '0;
        end
      end
      ST_PEND: begin
        if (int_csn_s && ext_csn_s) begin
          guard_nxt = (guard_cnt == GRD_W'(IDLE_GUARD)) ? guard_cnt : guard_cnt + GRD_W'(1);
        end
        if (guard_nxt == GRD_W'(IDLE_GUARD)) begin
          state_nxt = ST_EXT;
          guard_nxt = '0;
        end
      end
      ST_EXT: begin
        state_nxt = ST_EXT;
      end
      default: begin
        state_nxt = ST_INT;
      end
    endcase
  end

  // Registered source mux; switches one edge after entering EXT
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      mcu_sclk   <= 1'b0;
      mcu_csn    <= 1'b1;
      mcu_mosi   <= 1'b0;
      ext_active <= 1'b0;
    end else begin
      if (state == ST_EXT) begin
        mcu_sclk <= ext_sclk_s;
        mcu_csn  <= ext_csn_s;
        mcu_mosi <= ext_mosi_s;
      end else begin
        mcu_sclk <= int_sclk_s;
        mcu_csn  <= int_csn_s;
        mcu_mosi <= int_mosi_s;
      end
      ext_active <= (state_nxt == ST_EXT);
    end
  end

endmodule

// File: tb/tb_mcu_spi_select.sv
// Randomised bench for mcu_spi_select with a history-based reference model.
module tb_mcu_spi_select;

  localparam int SYNC  = 2;
  localparam int DET   = 16;
  localparam int GUARD = 4;
  localparam int HMAX  = 8192;
  localparam logic [5:0] RST_PADS = 6'b010010;

  logic clk32 = 1'b0;
  logic reset = 1'b0;
  logic int_sclk = 1'b0, int_csn = 1'b1, int_mosi = 1'b0;
  logic ext_sclk = 1'b0, ext_csn = 1'b1, ext_mosi = 1'b0;
  logic core_miso = 1'b0, core_intn = 1'b1;
  logic mcu_sclk, mcu_csn, mcu_mosi;
  logic int_miso, ext_miso, int_irqn, ext_irqn, ext_active;

  int vectors = 0;
  int miscompares = 0;

  mcu_spi_select #(
    .SYNC_STAGES(SYNC),
    .DET_CYCLES (DET),
    .IDLE_GUARD (GUARD)
  ) dut (
    .clk32     (clk32),
    .reset     (reset),
    .int_sclk  (int_sclk),
    .int_csn   (int_csn),
    .int_mosi  (int_mosi),
    .ext_sclk  (ext_sclk),
    .ext_csn   (ext_csn),
    .ext_mosi  (ext_mosi),
    .core_miso (core_miso),
    .core_intn (core_intn),
    .mcu_sclk  (mcu_sclk),
    .mcu_csn   (mcu_csn),
    .mcu_mosi  (mcu_mosi),
    .int_miso  (int_miso),
    .ext_miso  (ext_miso),
    .int_irqn  (int_irqn),
    .ext_irqn  (ext_irqn),
    .ext_active(ext_active)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pad history per edge since reset.
  // Edge n uses the pad value sampled SYNC edges earlier.
  // Qualification edge q: first edge whose last DET synced ext_csn values are all low.
  // Switch edge g: first edge after q whose last GUARD synced samples (all after q) have both csn high.
  logic [5:0] pad_h [HMAX];
  int n = 0, q = 0, g = 0;
  logic exp_sclk = 1'b0, exp_csn = 1'b1, exp_mosi = 1'b0, exp_act = 1'b0;

  function automatic logic [5:0] s_at(input int e);
    if (e - SYNC >= 1) return pad_h[e-SYNC];
    return RST_PADS;
  endfunction

  always @(posedge clk32 or posedge reset) begin
    logic [5:0] sv;
    bit ok;
    bit use_ext;
    if (reset) begin
      n = 0; q = 0; g = 0;
      exp_sclk = 1'b0; exp_csn = 1'b1; exp_mosi = 1'b0; exp_act = 1'b0;
    end else begin
      if (n < HMAX - 1) n++;
      pad_h[n] = {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk};
      if (q == 0 && n >= DET) begin
        ok = 1'b1;
        for (int e = n - DET + 1; e <= n; e++) begin
          sv = s_at(e);
          if (sv[4]) ok = 1'b0;
        end
        if (ok) q = n;
      end else if (q != 0 && g == 0 && (n - GUARD + 1) > q) begin
        ok = 1'b1;
        for (int e = n - GUARD + 1; e <= n; e++) begin
          sv = s_at(e);
          if (!(sv[1] && sv[4])) ok = 1'b0;
        end
        if (ok) g = n;
      end
      use_ext  = (g != 0) && (n > g);
      sv       = s_at(n);
      exp_sclk = use_ext ? sv[3] : sv[0];
      exp_csn  = use_ext ? sv[4] : sv[1];
      exp_mosi = use_ext ? sv[5] : sv[2];
      exp_act  = (g != 0) && (n >= g);
    end
  end

  // Compare process: every negedge, plus csn stability around the switch
  logic prev_act = 1'b0, prev_csn = 1'b1;
  always @(negedge clk32) begin
    chk("mcu_sclk", mcu_sclk, exp_sclk);
    chk("mcu_csn", mcu_csn, exp_csn);
    chk("mcu_mosi", mcu_mosi, exp_mosi);
    chk("ext_active", ext_active, exp_act);
    chk("int_miso", int_miso, core_miso);
    chk("ext_miso", ext_miso, core_miso);
    chk("int_irqn", int_irqn, core_intn);
    chk("ext_irqn", ext_irqn, core_intn);
    if (ext_active && !prev_act) begin
      chk("csn_before_switch", prev_csn, 1'b1);
      chk("csn_at_switch", mcu_csn, 1'b1);
    end
    prev_act = ext_active;
    prev_csn = mcu_csn;
  end

  task automatic tick();
    @(posedge clk32);
    #2;
    core_miso = 1'($urandom);
    core_intn = 1'($urandom);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic rand_data();
    int_sclk = 1'($urandom);
    int_mosi = 1'($urandom);
    ext_sclk = 1'($urandom);
    ext_mosi = 1'($urandom);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int int_run = 0, ext_run = 0;

  initial begin
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;

    // Internal traffic forwarded, ext data toggles while ext idle
    int_csn = 1'b0;
    ticks(4);
    int_mosi = 1'b0;
    tick();
    int_mosi = 1'b1;
    tick();
    tick();
    chk("latency_before", mcu_mosi, 1'b0);
    tick();
    chk("latency_at3", mcu_mosi, 1'b1);
    for (int i = 0; i < 60; i++) begin
      rand_data();
      int_csn = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Short ext pulses (15 cycles) never qualify
    for (int r = 0; r < 10; r++) begin
      ext_csn = 1'b0;
      for (int i = 0; i < 15; i++) begin rand_data(); int_csn = 1'($urandom); tick(); end
      ext_csn = 1'b1;
      for (int i = 0; i < 5; i++) begin rand_data(); int_csn = 1'($urandom); tick(); end
    end
    chk("short_pulses_ignored", ext_active, 1'b0);

    // Qualification with internal bus idle
    do_reset();
    int_csn = 1'b1;
    ext_csn = 1'b0;
    ticks(20);
    ext_csn = 1'b1;
    ticks(5);
    chk("idle_switch_not_yet", ext_active, 1'b0);
    tick();
    chk("idle_switch_at6", ext_active, 1'b1);
    for (int i = 0; i < 50; i++) begin
      rand_data();
      ext_csn = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Qualification during a long internal transfer
    do_reset();
    int_csn = 1'b0;
    ext_csn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 20) ext_csn = 1'b1;
      rand_data();
      tick();
    end
    chk("busy_no_switch", ext_active, 1'b0);
    int_csn = 1'b1;
    ticks(5);
    chk("busy_switch_not_yet", ext_active, 1'b0);
    tick();
    chk("busy_switch_at6", ext_active, 1'b1);
    for (int i = 0; i < 30; i++) begin
      rand_data();
      ext_csn = 1'($urandom);
      int_csn = 1'($urandom);
      tick();
    end

    // Async reset between edges while in EXT
    reset = 1'b1;
    #1;
    chk("async_rst_active", ext_active, 1'b0);
    chk("async_rst_csn", mcu_csn, 1'b1);
    chk("async_rst_sclk", mcu_sclk, 1'b0);
    tick();
    reset = 1'b0;
    ext_csn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_data();
      int_csn = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Fully random segments with mixed run lengths
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      int_run = 0;
      ext_run = 0;
      for (int i = 0; i < 400; i++) begin
        if (int_run == 0) begin
          int_csn = ~int_csn;
          int_run = $urandom_range(1, 12);
        end
        if (ext_run == 0) begin
          ext_csn = ~ext_csn;
          ext_run = ext_csn ? $urandom_range(1, 8) : $urandom_range(1, 24);
        end
        int_run--;
        ext_run--;
        rand_data();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcu_spi_select.md
Name: mcu_spi_select

Overview:
- Selects which MCU SPI source drives the core's mcu_* interface: the on-board BL616 (internal) or an external M0S Dock.
- Sits between the board pads and the core's mcu_sclk/mcu_csn/mcu_mosi inputs.
- Synchronises both sources into clk32 and qualifies M0S presence with a glitch filter.
- Changes source only while both buses are idle, then latches the external source until reset.
- Fans the core's MISO and interrupt back out to both MCUs.

Parameters:
SYNC_STAGES, 2, synchroniser depth per input bit (>=2).
DET_CYCLES, 16, consecutive synchronised cycles of ext_csn low that qualify M0S presence (>=1).
IDLE_GUARD, 4, consecutive cycles with both synchronised csn high required before switching (>=1).

Ports:
clk32  in  1  32 MHz system clock
reset  in  1  asynchronous, active-high reset
int_sclk  in  1  BL616 SPI clock
int_csn  in  1  BL616 chip select, active low
int_mosi  in  1  BL616 data to FPGA
ext_sclk  in  1  M0S SPI clock
ext_csn  in  1  M0S chip select, active low
ext_mosi  in  1  M0S data to FPGA
core_miso  in  1  core data to MCU
core_intn  in  1  core interrupt, active low
mcu_sclk  out  1  selected SPI clock to core
mcu_csn  out  1  selected chip select to core
mcu_mosi  out  1  selected data to core
int_miso  out  1  core_miso to BL616
ext_miso  out  1  core_miso to M0S
int_irqn  out  1  core_intn to BL616
ext_irqn  out  1  core_intn to M0S
ext_active  out  1  1 when the external source is selected

Behaviour:
- Reset state:
  - Synchroniser flops: csn chains to 1, sclk/mosi chains to 0.
  - State INT. All counters 0.
  - Outputs: mcu_csn=1, mcu_sclk=0, mcu_mosi=0, ext_active=0.
- Synchronisation: each of the six inputs passes through SYNC_STAGES flops, giving *_s signals.
- Output register: mcu_* are registered muxes of the *_s signals. Pad-to-output latency is SYNC_STAGES+1 cycles.
- Source mux: INT and PEND forward int_*_s. EXT forwards ext_*_s.
- Fan-out paths are combinational, with no latency and unaffected by state:
  - int_miso = ext_miso = core_miso.
  - int_irqn = ext_irqn = core_intn.
- det_cnt:
  - Increments while ext_csn_s==0 and saturates at DET_CYCLES.
  - Clears to 0 on any cycle with ext_csn_s==1.
  - Counts in INT only; held at 0 in PEND and EXT.
- guard_cnt:
  - Counts in PEND only. Increments while int_csn_s==1 and ext_csn_s==1; clears otherwise.
  - Saturates at IDLE_GUARD.
- FSM:
  - INT -> PEND on the cycle det_cnt reaches DET_CYCLES.
  - PEND -> EXT on the cycle guard_cnt reaches IDLE_GUARD. On that same edge:
    - ext_active becomes 1.
    - The mux switches, so the next registered output samples ext_*_s.
  - EXT is terminal. Only reset leaves EXT, returning to INT.
- Boundary rules:
  - An ext_csn low pulse shorter than DET_CYCLES is ignored, and the counter restarts from 0 on the next low.
  - Qualification during an active internal transfer (int_csn low): stay in PEND and keep forwarding internal until both buses have been idle for IDLE_GUARD cycles. An internal transfer is never cut mid-frame.
  - The M0S frame that triggered detection is never forwarded. The M0S firmware retries it.
  - mcu_csn is high on the cycles before and after the switch edge, so the core sees no spurious csn edge.
  - Async reset mid-PEND or mid-EXT clears to the reset state immediately, with no clock required.
  - DET_CYCLES=1 is legal: a single low synchronised cycle qualifies.

Test Plan:
- Reset, then toggle int_sclk/int_mosi with int_csn low and ext idle high -> mcu_* follow int_* 3 cycles later; ext_active=0; ext_* toggles never appear on the outputs.
- ext_csn low for 15 cycles then high, repeated 10 times -> state stays INT, ext_active=0, mcu_csn continues to track int_csn.
- ext_csn low 20 cycles then high, with int_csn high throughout -> PEND after the 16th synchronised low cycle. ext_active=1 exactly 4 cycles after ext_csn_s returns high. Subsequent ext frames appear on mcu_* with 3-cycle latency.
- int_csn held low for 100 cycles while ext_csn qualifies -> ext_active stays 0 until 4 cycles after both are high. mcu_csn shows no low-high-low glitch across the switch.
- Assert reset asynchronously in EXT, between clock edges -> ext_active=0 and mcu_csn=1 immediately. After release, the internal source is forwarded again.
- Toggle core_miso and core_intn in every state -> int_miso, ext_miso, int_irqn and ext_irqn equal their sources in the same cycle.
